// File: rtl/mips_pkg.sv
// Shared MIPS-style definitions: instruction field positions, fetch FSM
// states, opcode type and the default halt encoding.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = 6;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int REG_W      = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int FUNCT_W    = 6;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = 16;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  typedef logic [OPCODE_W-1:0] opcode_t;

  // All register-index fields (rs/rt/rd/shamt) share the same width.
  function automatic logic [REG_W-1:0] reg_field(input logic [WORD_W-1:0] word,
                                                 input int lsb);
    return word[lsb +: REG_W];
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: one synchronous read port, one write port. The read
// data register holds its value while re is low, so a stalled fetch keeps it.
module instr_mem
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = WORD_W,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem_reg [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_reg;

  // Non-blocking write means a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem_reg[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sequential PC, 1-cycle memory, one-entry output
// register with valid/ready handshake, redirect and halt handling, field decode.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int          PC_W      = 8,
  parameter int          INSTR_W   = WORD_W,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT,
  parameter              INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic [15:0]        imm,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  localparam logic [1:0] ST_IDLE = 2'(FETCH_IDLE);
  localparam logic [1:0] ST_RUN  = 2'(FETCH_RUN);
  localparam logic [1:0] ST_HALT = 2'(FETCH_HALT);

  logic [1:0]         state_reg, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic               flight_reg, flight_next;
  logic [PC_W-1:0]    flight_pc_reg, flight_pc_next;
  logic               valid_reg, valid_next;
  logic [INSTR_W-1:0] instr_reg, instr_next;
  logic [PC_W-1:0]    pc_out_reg, pc_out_next;
  logic [31:0]        count_reg, count_next;

  logic [INSTR_W-1:0] mem_rdata;
  logic               accept;
  logic               halt_shown;
  logic               out_free;
  logic               issue;
  logic               rd_en;
  logic [PC_W-1:0]    rd_addr;

  assign accept     = valid_reg & out_ready;
  assign halt_shown = valid_reg & (instr_reg == HALT_WORD);
  assign out_free   = ~valid_reg | accept;
  assign issue      = (state_reg == ST_RUN) & en & out_free & ~halt_shown;

  // A redirect fetches its target on the redirect edge itself.
  assign rd_en   = redirect_valid ? en : issue;
  assign rd_addr = redirect_valid ? redirect_pc : pc_reg;

  instr_mem #(
    .ADDR_W    (PC_W),
    .DATA_W    (INSTR_W),
    .INIT_FILE (INIT_FILE)
  ) u_instr_mem (
    .clk   (clk),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (mem_rdata),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata)
  );

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    flight_next    = flight_reg;
    flight_pc_next = flight_pc_reg;
    valid_next     = valid_reg;
    instr_next     = instr_reg;
    pc_out_next    = pc_out_reg;
    count_next     = accept ? count_reg + 32'd1 : count_reg;

    if (redirect_valid) begin
      state_next     = ST_RUN;
      valid_next     = 1'b0;
      flight_next    = en;
      flight_pc_next = redirect_pc;
      pc_next        = en ? PC_W'(redirect_pc + 1'b1) : redirect_pc;
    end else if (halt_shown) begin
      // Anything fetched behind the halt word is dropped.
      flight_next = 1'b0;
      if (accept) begin
        valid_next = 1'b0;
        if (state_reg == ST_RUN) begin
          state_next = ST_HALT;
        end
      end
    end else begin
      if (flight_reg && out_free) begin
        valid_next  = 1'b1;
        instr_next  = mem_rdata;
        pc_out_next = flight_pc_reg;
      end else if (accept) begin
        valid_next = 1'b0;
      end
      // An unconsumed read stays parked in the memory's read register.
      flight_next = issue | (flight_reg & ~out_free);
      if (issue) begin
        flight_pc_next = pc_reg;
        pc_next        = PC_W'(pc_reg + 1'b1);
      end
      if (state_reg == ST_IDLE && en) begin
        state_next = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= '0;
      flight_reg    <= 1'b0;
      flight_pc_reg <= '0;
      valid_reg     <= 1'b0;
      instr_reg     <= '0;
      pc_out_reg    <= '0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      flight_reg    <= flight_next;
      flight_pc_reg <= flight_pc_next;
      valid_reg     <= valid_next;
      instr_reg     <= instr_next;
      pc_out_reg    <= pc_out_next;
      count_reg     <= count_next;
    end
  end

  assign out_valid   = valid_reg;
  assign pc_o        = pc_out_reg;
  assign instr_o     = instr_reg;
  assign halted      = (state_reg == ST_HALT);
  assign fetch_count = count_reg;

  assign opcode = opcode_t'(instr_reg[OPCODE_LSB +: OPCODE_W]);
  assign rs     = reg_field(instr_reg, RS_LSB);
  assign rt     = reg_field(instr_reg, RT_LSB);
  assign rd     = reg_field(instr_reg, RD_LSB);
  assign shamt  = reg_field(instr_reg, SHAMT_LSB);
  assign funct  = instr_reg[FUNCT_LSB +: FUNCT_W];
  assign imm    = instr_reg[IMM_LSB +: IMM_W];

endmodule
